// File: rtl/wave_gen_multi_if.sv
// Sample stream between the waveform generator and its consumer.
// Handshake: a beat transfers on a rising clock edge where sample_valid and
// sample_ready are both high. Once sample_valid is raised, it stays high and
// sample_data, sample_channel and frame_start stay stable until that beat
// transfers. The only exception is reset. sample_ready may change freely
// while sample_valid is low.
interface wave_gen_multi_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CH_W       = 1
);
    logic                  sample_valid;
    logic                  sample_ready;
    logic [DATA_WIDTH-1:0] sample_data;
    logic [CH_W-1:0]       sample_channel;
    logic                  frame_start;

    modport master (
        output sample_valid,
        output sample_data,
        output sample_channel,
        output frame_start,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  sample_data,
        input  sample_channel,
        input  frame_start,
        output sample_ready
    );
endinterface

// File: rtl/wave_gen_multi.sv
// Multi-channel waveform source. It walks a host-written one-period table,
// or it synthesises a square or sawtooth wave from the table position. It
// then applies an attenuation shift. Each frame emits one beat per channel.
// Adjacent channels are phase-shifted by ch_offset. Successive frames advance
// by step. All shaping parameters are latched at the start of a frame.
module wave_gen_multi #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int CHANNELS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] wavelength,
    input  logic [ADDR_WIDTH-1:0] step,
    input  logic [ADDR_WIDTH-1:0] ch_offset,
    input  logic [3:0]            atten,
    input  logic                  tbl_wr_en,
    input  logic [ADDR_WIDTH-1:0] tbl_wr_addr,
    input  logic [DATA_WIDTH-1:0] tbl_wr_data,
    output logic [1:0]            dbg_state,
    wave_gen_multi_if.master      smp
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int AW1   = ADDR_WIDTH + 1;
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [CH_W-1:0]       LAST_CH  = CH_W'(CHANNELS - 1);
    localparam logic [ADDR_WIDTH-1:0] MSB_MASK = ADDR_WIDTH'(1) << (ADDR_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] SQ_POS   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SQ_NEG   = {1'b1, {(DATA_WIDTH-2){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        SHAPE   = 2'd2,
        PRESENT = 2'd3
    } state_t;

    // Advance a table position by inc within a period of len entries. The
    // second compare catches increments of len or more, which collapse to 0.
    function automatic logic [ADDR_WIDTH-1:0] wrap(
        input logic [ADDR_WIDTH-1:0] pos,
        input logic [ADDR_WIDTH-1:0] inc,
        input logic [AW1-1:0]        len
    );
        logic [AW1-1:0] s;
        s = {1'b0, pos} + {1'b0, inc};
        if (s >= len) s = s - len;
        if (s >= len) s = '0;
        return s[ADDR_WIDTH-1:0];
    endfunction

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_pos_q, base_pos_d;
    logic [ADDR_WIDTH-1:0]   ch_pos_q, ch_pos_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [1:0]              mode_q, mode_d;
    logic [AW1-1:0]          len_q, len_d;
    logic [ADDR_WIDTH-1:0]   step_q, step_d;
    logic [ADDR_WIDTH-1:0]   offs_q, offs_d;
    logic [3:0]              atten_q, atten_d;
    logic                    valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [CH_W-1:0]         channel_q, channel_d;
    logic                    frame_start_q, frame_start_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_data_q;

    logic [AW1-1:0]          eff_len;
    logic [ADDR_WIDTH-1:0]   base_adv;
    logic [ADDR_WIDTH-1:0]   saw_pos;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] saw_wide;
    logic signed [DATA_WIDTH-1:0] shape;
    logic signed [DATA_WIDTH-1:0] shaped;

    assign eff_len  = (wavelength == '0) ? AW1'(1) : {1'b0, wavelength};
    assign base_adv = wrap(base_pos_q, step_q, len_q);

    // Table port: host writes land any cycle. The read happens in READ and
    // returns the pre-write contents when both hit the same address.
    always_ff @(posedge clk) begin
        if (tbl_wr_en) mem[tbl_wr_addr] <= tbl_wr_data;
        if (state_q == READ) rd_data_q <= mem[ch_pos_q];
    end

    // Wave shaping from the latched mode and the current channel position.
    always_comb begin
        saw_pos  = ch_pos_q ^ MSB_MASK;
        saw_wide = {saw_pos, {DATA_WIDTH{1'b0}}};
        shape    = '0;
        unique case (mode_q)
            2'd0: shape = rd_data_q;
            2'd1: shape = ({1'b0, ch_pos_q} < (len_q >> 1)) ? SQ_POS : SQ_NEG;
            2'd2: shape = saw_wide[ADDR_WIDTH+DATA_WIDTH-1 -: DATA_WIDTH];
            default: shape = '0;
        endcase
        shaped = shape >>> atten_q;
    end

    // Frame sequencing, parameter latching and output beat registers.
    always_comb begin
        state_d       = state_q;
        base_pos_d    = base_pos_q;
        ch_pos_d      = ch_pos_q;
        ch_d          = ch_q;
        mode_d        = mode_q;
        len_d         = len_q;
        step_d        = step_q;
        offs_d        = offs_q;
        atten_d       = atten_q;
        valid_d       = valid_q;
        data_d        = data_q;
        channel_d     = channel_q;
        frame_start_d = frame_start_q;

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    mode_d   = mode;
                    len_d    = eff_len;
                    step_d   = step;
                    offs_d   = ch_offset;
                    atten_d  = atten;
                    ch_d     = '0;
                    ch_pos_d = base_pos_q;
                    state_d  = READ;
                end
            end
            READ: begin
                state_d = SHAPE;
            end
            SHAPE: begin
                data_d        = shaped;
                channel_d     = ch_q;
                frame_start_d = (ch_q == '0);
                valid_d       = 1'b1;
                state_d       = PRESENT;
            end
            PRESENT: begin
                if (valid_q && smp.sample_ready) begin
                    valid_d = 1'b0;
                    if (ch_q != LAST_CH) begin
                        ch_d     = ch_q + 1'b1;
                        ch_pos_d = wrap(ch_pos_q, offs_q, len_q);
                        state_d  = READ;
                    end else begin
                        base_pos_d = base_adv;
                        if (enable) begin
                            mode_d   = mode;
                            len_d    = eff_len;
                            step_d   = step;
                            offs_d   = ch_offset;
                            atten_d  = atten;
                            ch_d     = '0;
                            ch_pos_d = base_adv;
                            state_d  = READ;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset; table contents are left alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            base_pos_q    <= '0;
            ch_pos_q      <= '0;
            ch_q          <= '0;
            mode_q        <= '0;
            len_q         <= AW1'(1);
            step_q        <= '0;
            offs_q        <= '0;
            atten_q       <= '0;
            valid_q       <= 1'b0;
            data_q        <= '0;
            channel_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_pos_q    <= base_pos_d;
            ch_pos_q      <= ch_pos_d;
            ch_q          <= ch_d;
            mode_q        <= mode_d;
            len_q         <= len_d;
            step_q        <= step_d;
            offs_q        <= offs_d;
            atten_q       <= atten_d;
            valid_q       <= valid_d;
            data_q        <= data_d;
            channel_q     <= channel_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign smp.sample_valid   = valid_q;
    assign smp.sample_data    = data_q;
    assign smp.sample_channel = channel_q;
    assign smp.frame_start    = frame_start_q;
    assign dbg_state          = state_q;

endmodule

// File: tb/tb_wave_gen_multi.sv
// Directed and randomized bench for wave_gen_multi (16-bit data, 8-bit
// addresses, 2 channels). Expected beats come from a positional model:
// position = (frame*step + channel*offset) mod L.
module tb_wave_gen_multi;

    localparam int DW  = 16;
    localparam int AW  = 8;
    localparam int NCH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [1:0]    mode;
    logic [AW-1:0] wavelength;
    logic [AW-1:0] step;
    logic [AW-1:0] ch_offset;
    logic [3:0]    atten;
    logic          tbl_wr_en;
    logic [AW-1:0] tbl_wr_addr;
    logic [DW-1:0] tbl_wr_data;
    logic [1:0]    dbg_state;

    wave_gen_multi_if #(.DATA_WIDTH(DW), .CH_W(1)) sif ();

    wave_gen_multi #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CHANNELS(NCH)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .mode       (mode),
        .wavelength (wavelength),
        .step       (step),
        .ch_offset  (ch_offset),
        .atten      (atten),
        .tbl_wr_en  (tbl_wr_en),
        .tbl_wr_addr(tbl_wr_addr),
        .tbl_wr_data(tbl_wr_data),
        .dbg_state  (dbg_state),
        .smp        (sif)
    );

    // Clock and reset-time defaults.
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state: table image and the parameters of the running frame.
    int tbl [256];
    int m_mode, m_len, m_step, m_off, m_att;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] got [0:45][0:1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Shaped sample for a table position, computed from the mode rules.
    function automatic logic [DW-1:0] model(input int md, input int pos, input int att);
        int s;
        case (md)
            0:       s = tbl[pos];
            1:       s = (pos < m_len / 2) ? 32767 : -32767;
            2:       s = (pos - 128) * 256;
            default: s = 0;
        endcase
        s = s >>> att;
        return s[DW-1:0];
    endfunction

    function automatic int pos_of(input int f, input int c);
        return (f * m_step + c * m_off) % m_len;
    endfunction

    task automatic write_tbl(input int a, input int v);
        logic [DW-1:0] v16;
        v16 = v[DW-1:0];
        @(negedge clk);
        tbl_wr_en   = 1'b1;
        tbl_wr_addr = a[AW-1:0];
        tbl_wr_data = v16;
        tbl[a]      = int'($signed(v16));
        @(negedge clk);
        tbl_wr_en   = 1'b0;
    endtask

    task automatic cfg(input int md, input int wl, input int st, input int of, input int at);
        mode       = md[1:0];
        wavelength = wl[AW-1:0];
        step       = st[AW-1:0];
        ch_offset  = of[AW-1:0];
        atten      = at[3:0];
        m_mode = md; m_len = (wl == 0) ? 1 : wl; m_step = st; m_off = of; m_att = at;
    endtask

    task automatic restart();
        enable           = 1'b0;
        sif.sample_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Wait for a beat, hold it off for 'hold' cycles while checking that it
    // stays put, then accept it. waited counts negedges until acceptance.
    task automatic get_beat(input int hold, output logic [DW-1:0] d, output int chn,
                            output logic fs, output int waited);
        int h;
        bit held, got_it;
        logic [DW-1:0] hd;
        logic hc, hfs;
        h = hold; held = 0; got_it = 0; waited = 0;
        d = '0; chn = -1; fs = 1'b0;
        while (!got_it && waited < 100) begin
            @(negedge clk);
            waited++;
            if (sif.sample_valid) begin
                if (held) begin
                    check("hold_data", sif.sample_data, hd);
                    check("hold_chan", sif.sample_channel, hc);
                    check("hold_fs", sif.frame_start, hfs);
                end
                if (h > 0) begin
                    sif.sample_ready = 1'b0;
                    hd = sif.sample_data; hc = sif.sample_channel; hfs = sif.frame_start;
                    held = 1; h--;
                end else begin
                    sif.sample_ready = 1'b1;
                    d = sif.sample_data; chn = int'(sif.sample_channel); fs = sif.frame_start;
                    got_it = 1;
                end
            end else begin
                if (held) check("hold_valid", sif.sample_valid, 1'b1);
                sif.sample_ready = 1'($urandom_range(0, 1));
            end
        end
        check("beat_timeout", got_it, 1'b1);
    endtask

    // Receive one beat and score it against the head of exp_q.
    task automatic run_beat(input int hold, input int c, output logic [DW-1:0] d);
        logic fs;
        int chn, waited;
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        get_beat(hold, d, chn, fs, waited);
        check("beat_data", d, e);
        check("beat_chan", chn, c);
        check("beat_fs", fs, (c == 0));
        check("beat_gap", waited, 3 + hold);
    endtask

    task automatic run_frame(input int f, input int hold_max);
        logic [DW-1:0] d;
        for (int c = 0; c < NCH; c++) exp_q.push_back(model(m_mode, pos_of(f, c), m_att));
        for (int c = 0; c < NCH; c++) begin
            run_beat($urandom_range(0, hold_max), c, d);
            if (f <= 45) got[f][c] = d;
        end
    endtask

    initial begin
        logic [DW-1:0] d;
        int n;
        rst = 1'b1; enable = 1'b0; tbl_wr_en = 1'b0; tbl_wr_addr = '0; tbl_wr_data = '0;
        sif.sample_ready = 1'b0;
        cfg(0, 44, 1, 11, 0);
        repeat (3) @(negedge clk);
        check("rst_valid", sif.sample_valid, 1'b0);
        check("rst_data", sif.sample_data, 16'h0000);
        check("rst_chan", sif.sample_channel, 1'b0);
        check("rst_fs", sif.frame_start, 1'b0);
        rst = 1'b0;

        // Sine period of 44 entries, scaled by 32768 and clamped to +max.
        for (int i = 0; i < 44; i++) begin
            real r;
            int v;
            r = 32768.0 * $sin(6.283185307179586 * i / 44.0);
            v = (r >= 0.0) ? $rtoi(r + 0.5) : $rtoi(r - 0.5);
            if (v > 32767) v = 32767;
            write_tbl(i, v);
        end

        // Table walk across a full period plus wrap, then a long hold-off.
        restart();
        cfg(0, 44, 1, 11, 0);
        enable = 1'b1;
        for (int f = 0; f < 45; f++) run_frame(f, 0);
        check("sine_f0c0", got[0][0], 16'h0000);
        check("sine_f0c1", got[0][1], 16'h7FFF);
        check("sine_f1c0", got[1][0], 16'h1237);
        check("sine_f1c1", got[1][1], 16'h7EB2);
        check("sine_f43c1", got[43][1], 16'h7EB2);
        check("sine_f44c0", got[44][0], 16'h0000);
        exp_q.push_back(model(0, pos_of(45, 0), 0));
        exp_q.push_back(model(0, pos_of(45, 1), 0));
        run_beat(10, 0, d);
        run_beat(0, 1, d);

        // Square and mute.
        restart();
        cfg(1, 8, 1, 3, 0);
        enable = 1'b1;
        for (int f = 0; f < 16; f++) begin
            run_frame(f, 1);
            check("square_seq", got[f][0], ((f % 8) < 4) ? 16'h7FFF : 16'h8001);
        end
        restart();
        cfg(3, 44, 1, 11, 0);
        enable = 1'b1;
        for (int f = 0; f < 6; f++) run_frame(f, 0);

        // Attenuation and mid-frame parameter change.
        restart();
        write_tbl(0, 32'h7FFF);
        write_tbl(1, 32'h8001);
        cfg(0, 2, 1, 1, 1);
        enable = 1'b1;
        exp_q.push_back(model(0, 0, 1));
        exp_q.push_back(model(0, 1, 1));
        run_beat(0, 0, d);
        check("atten1_pos", d, 16'h3FFF);
        atten = 4'd15;
        run_beat(0, 1, d);
        check("atten1_neg", d, 16'hC000);
        exp_q.push_back(model(0, 1, 15));
        exp_q.push_back(model(0, 0, 15));
        run_beat(0, 0, d);
        check("atten15_neg", d, 16'hFFFF);
        run_beat(0, 1, d);
        check("atten15_pos", d, 16'h0000);

        // Enable dropped during ch0: frame completes, then idle, then resume.
        restart();
        cfg(0, 44, 5, 7, 0);
        enable = 1'b1;
        exp_q.push_back(model(0, pos_of(0, 0), 0));
        exp_q.push_back(model(0, pos_of(0, 1), 0));
        run_beat(0, 0, d);
        enable = 1'b0;
        run_beat(0, 1, d);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_valid", sif.sample_valid, 1'b0);
        end
        enable = 1'b1;
        run_frame(1, 0);

        // Reset while a beat is pending.
        sif.sample_ready = 1'b0;
        n = 0;
        while (!sif.sample_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("pending_valid", sif.sample_valid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_drop_valid", sif.sample_valid, 1'b0);
        check("rst_drop_data", sif.sample_data, 16'h0000);
        run_frame(0, 0);

        // Randomized runs over tables, modes and parameters.
        for (int run = 0; run < 4; run++) begin
            int wl, len;
            restart();
            for (int a = 0; a < 256; a++) write_tbl(a, int'($urandom_range(0, 65535)));
            wl  = int'($urandom_range(0, 255));
            len = (wl == 0) ? 1 : wl;
            cfg(int'($urandom_range(0, 3)), wl, int'($urandom_range(0, len - 1)),
                int'($urandom_range(0, len - 1)), int'($urandom_range(0, 15)));
            enable = 1'b1;
            for (int f = 0; f < 6; f++) run_frame(f, 2);
        end

        enable = 1'b0;
        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
